// File: rtl/muldiv_unit_pkg.sv
// Shared constants for the iterative RV64M multiply/divide unit:
// funct3 opcodes, FSM state encoding and the most-negative operand value.
package muldiv_unit_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Most-negative two's-complement value for a given operand width (<= 64).
  function automatic logic [63:0] most_neg(input int size);
    return 64'd1 << (size - 1);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the multiply/divide
// unit; the result side feeds the register file write port directly.
interface muldiv_unit_if #(
  parameter int SIZE = 64
);
  logic            start;
  logic [2:0]      op;
  logic [SIZE-1:0] a;
  logic [SIZE-1:0] b;
  logic [4:0]      rd;
  logic            busy;
  logic            done;
  logic [SIZE-1:0] dout;
  logic [4:0]      rw;
  logic            we;

  modport master (
    output start, op, a, b, rd,
    input  busy, done, dout, rw, we
  );

  modport slave (
    input  start, op, a, b, rd,
    output busy, done, dout, rw, we
  );
endinterface

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate: turns signed operands into magnitudes
// on entry and restores the result sign on exit.
module muldiv_signfix #(
  parameter int W = 64
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide: shift-add multiplier and restoring divider
// sharing one hi/lo register pair, one result bit per cycle, SIZE+2 latency.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int SIZE  = 64,
  parameter int CNT_W = 7
) (
  input logic           clk,
  input logic           rst,
  muldiv_unit_if.slave  m
);

  localparam logic [SIZE-1:0]  MIN_NEG  = SIZE'(most_neg(SIZE));
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SIZE - 1);

  state_t           state_reg;
  logic [SIZE-1:0]  hi_reg, lo_reg, opb_reg;
  logic [SIZE-1:0]  a_reg, b_reg;
  logic [2:0]       op_reg;
  logic [4:0]       rd_reg;
  logic             res_neg_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             busy_reg, done_reg, we_reg;
  logic [SIZE-1:0]  dout_reg;
  logic [4:0]       rw_reg;

  // Operand entry: magnitudes of A and B according to the op's signedness.
  logic            sgn_a, sgn_b, entry_neg;
  logic [SIZE-1:0] opnd     [2];
  logic            opnd_neg [2];
  logic [SIZE-1:0] mag      [2];

  assign sgn_a = (m.op == OP_MULH) || (m.op == OP_MULHSU) ||
                 (m.op == OP_DIV)  || (m.op == OP_REM);
  assign sgn_b = (m.op == OP_MULH) || (m.op == OP_DIV) || (m.op == OP_REM);

  assign opnd[0]     = m.a;
  assign opnd[1]     = m.b;
  assign opnd_neg[0] = sgn_a & m.a[SIZE-1];
  assign opnd_neg[1] = sgn_b & m.b[SIZE-1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      muldiv_signfix #(.W(SIZE)) u_fix (
        .val (opnd[gi]),
        .neg (opnd_neg[gi]),
        .res (mag[gi])
      );
    end
  endgenerate

  // Remainder follows the dividend's sign; everything else takes sign(A)^sign(B).
  assign entry_neg = (m.op[2:1] == 2'b11) ? opnd_neg[0] : (opnd_neg[0] ^ opnd_neg[1]);

  // One iteration: lo holds multiplier/dividend, hi accumulates product/remainder.
  logic [SIZE:0]   mul_sum, div_shift;
  logic            div_ge;
  logic [SIZE-1:0] hi_next, lo_next;

  assign mul_sum   = {1'b0, hi_reg} + {1'b0, opb_reg & {SIZE{lo_reg[0]}}};
  assign div_shift = {hi_reg, lo_reg[SIZE-1]};
  assign div_ge    = div_shift >= {1'b0, opb_reg};

  always_comb begin
    hi_next = hi_reg;
    lo_next = lo_reg;
    if (op_reg[2]) begin
      hi_next = div_ge ? SIZE'(div_shift - {1'b0, opb_reg}) : div_shift[SIZE-1:0];
      lo_next = {lo_reg[SIZE-2:0], div_ge};
    end else begin
      hi_next = mul_sum[SIZE:1];
      lo_next = {mul_sum[0], lo_reg[SIZE-1:1]};
    end
  end

  // Result exit: sign-correct the full double-width value, then select.
  logic [2*SIZE-1:0] res_sel, res_fix;
  logic              b_zero, ovf;
  logic [SIZE-1:0]   dout_next;

  always_comb begin
    res_sel = {hi_reg, lo_reg};
    if (op_reg[2]) begin
      res_sel = op_reg[1] ? {{SIZE{1'b0}}, hi_reg} : {{SIZE{1'b0}}, lo_reg};
    end
  end

  muldiv_signfix #(.W(2*SIZE)) u_exit_fix (
    .val (res_sel),
    .neg (res_neg_reg),
    .res (res_fix)
  );

  assign b_zero = (b_reg == '0);
  assign ovf    = ((op_reg == OP_DIV) || (op_reg == OP_REM)) &&
                  (a_reg == MIN_NEG) && (b_reg == '1);

  always_comb begin
    dout_next = res_fix[SIZE-1:0];
    case (op_reg)
      OP_MUL:                       dout_next = res_fix[SIZE-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: dout_next = res_fix[2*SIZE-1:SIZE];
      OP_DIV, OP_DIVU:              dout_next = b_zero ? '1 : (ovf ? MIN_NEG : res_fix[SIZE-1:0]);
      default:                      dout_next = b_zero ? a_reg : (ovf ? '0 : res_fix[SIZE-1:0]);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      hi_reg      <= '0;
      lo_reg      <= '0;
      opb_reg     <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      op_reg      <= '0;
      rd_reg      <= '0;
      res_neg_reg <= 1'b0;
      cnt_reg     <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      we_reg      <= 1'b0;
      dout_reg    <= '0;
      rw_reg      <= '0;
    end else begin
      done_reg <= 1'b0;
      we_reg   <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (m.start) begin
            hi_reg      <= '0;
            lo_reg      <= mag[0];
            opb_reg     <= mag[1];
            a_reg       <= m.a;
            b_reg       <= m.b;
            op_reg      <= m.op;
            rd_reg      <= m.rd;
            res_neg_reg <= entry_neg;
            cnt_reg     <= '0;
            busy_reg    <= 1'b1;
            state_reg   <= ST_CALC;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        ST_CALC: begin
          hi_reg  <= hi_next;
          lo_reg  <= lo_next;
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (cnt_reg == LAST_CNT) begin
            state_reg <= ST_FIX;
          end
        end
        ST_FIX: begin
          dout_reg  <= dout_next;
          rw_reg    <= rd_reg;
          done_reg  <= 1'b1;
          we_reg    <= (rd_reg != 5'd0);
          busy_reg  <= 1'b0;
          state_reg <= ST_DONE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign m.busy = busy_reg;
  assign m.done = done_reg;
  assign m.we   = we_reg;
  assign m.dout = dout_reg;
  assign m.rw   = rw_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed corner cases plus random ops, each checked
// against a plain-arithmetic RV64M reference for value, writeback and latency.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int          SIZE  = 64;
  localparam int          LAT   = SIZE + 2;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  muldiv_unit_if #(.SIZE(SIZE)) dif ();

  muldiv_unit #(.SIZE(SIZE), .CNT_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .m   (dif)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [63:0] a,
                                        input logic [63:0] b);
    logic [127:0] ax, bx, p;
    ax = (op == OP_MULH || op == OP_MULHSU) ? {{64{a[63]}}, a} : {64'd0, a};
    bx = (op == OP_MULH) ? {{64{b[63]}}, b} : {64'd0, b};
    p  = ax * bx;
    case (op)
      OP_MUL:                       return p[63:0];
      OP_MULH, OP_MULHSU, OP_MULHU: return p[127:64];
      OP_DIV: begin
        if (b == 64'd0) return ONES;
        if (a == MIN64 && b == ONES) return a;
        return 64'($signed(a) / $signed(b));
      end
      OP_DIVU: return (b == 64'd0) ? ONES : a / b;
      OP_REM: begin
        if (b == 64'd0) return a;
        if (a == MIN64 && b == ONES) return 64'd0;
        return 64'($signed(a) % $signed(b));
      end
      default: return (b == 64'd0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [63:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return ONES;
      2:       return MIN64;
      3:       return 64'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Called just after a clock edge; request is accepted on the next edge,
  // after which the inputs are scrambled to prove they were latched.
  task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd);
    dif.op    = op;
    dif.a     = a;
    dif.b     = b;
    dif.rd    = rd;
    dif.start = 1'b1;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    dif.op    = 3'($urandom);
    dif.a     = {$urandom, $urandom};
    dif.b     = {$urandom, $urandom};
    dif.rd    = 5'($urandom);
  endtask

  // Waits (bounded) for DONE; leaves time inside the DONE cycle.
  task automatic expect_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                           input logic [4:0] rd, input bit poke);
    logic [63:0] exp;
    int          n;
    bit          busy_ok;
    exp     = model(op, a, b);
    n       = 1;
    busy_ok = 1'b1;
    while (dif.done !== 1'b1 && n < 4 * LAT) begin
      if (dif.busy !== 1'b1) busy_ok = 1'b0;
      if (poke && n == 10) begin
        dif.start = 1'b1;
        dif.op    = OP_MUL;
      end
      @(posedge clk);
      #1;
      dif.start = 1'b0;
      n++;
    end
    check("latency", 64'(n), 64'(LAT));
    check("busy_during_op", 64'(busy_ok), 64'd1);
    check("busy_at_done", 64'(dif.busy), 64'd0);
    check("dout", dif.dout, exp);
    check("rw", 64'(dif.rw), 64'(rd));
    check("we", 64'(dif.we), 64'(rd != 5'd0));
    $display("op=%0d a=%h b=%h rd=%0d dout=%h exp=%h we=%0b lat=%0d",
             op, a, b, rd, dif.dout, exp, dif.we, n);
  endtask

  task automatic settle(input logic [63:0] held);
    @(posedge clk);
    #1;
    check("done_pulse", 64'(dif.done), 64'd0);
    check("we_pulse", 64'(dif.we), 64'd0);
    check("dout_hold", dif.dout, held);
  endtask

  initial begin
    logic [2:0]  op;
    logic [63:0] a, b;
    logic [4:0]  rd;
    bit          saw_done;

    dif.start = 1'b0;
    dif.op    = 3'd0;
    dif.a     = 64'd0;
    dif.b     = 64'd0;
    dif.rd    = 5'd0;

    // Reset asserted between clock edges must act immediately.
    #2 rst = 1'b1;
    #1;
    check("rst_busy", 64'(dif.busy), 64'd0);
    check("rst_done", 64'(dif.done), 64'd0);
    check("rst_we", 64'(dif.we), 64'd0);
    check("rst_dout", dif.dout, 64'd0);
    check("rst_rw", 64'(dif.rw), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    issue(OP_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5);
    expect_op(OP_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 1'b0);
    check("plan_mul", dif.dout, 64'hFFFF_FFFF_FFFF_FFEB);
    settle(64'hFFFF_FFFF_FFFF_FFEB);

    issue(OP_MULHU, ONES, ONES, 5'd1);
    expect_op(OP_MULHU, ONES, ONES, 5'd1, 1'b1);
    check("plan_mulhu", dif.dout, 64'hFFFF_FFFF_FFFF_FFFE);
    settle(64'hFFFF_FFFF_FFFF_FFFE);

    issue(OP_MULH, ONES, ONES, 5'd2);
    expect_op(OP_MULH, ONES, ONES, 5'd2, 1'b0);
    check("plan_mulh", dif.dout, 64'd0);
    settle(64'd0);

    // DIV followed by REM accepted in the DIV DONE cycle.
    issue(OP_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd3);
    expect_op(OP_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd3, 1'b0);
    check("plan_div", dif.dout, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(OP_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd4);
    expect_op(OP_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd4, 1'b0);
    check("plan_rem", dif.dout, ONES);
    settle(ONES);

    issue(OP_DIVU, 64'd5, 64'd0, 5'd6);
    expect_op(OP_DIVU, 64'd5, 64'd0, 5'd6, 1'b0);
    check("plan_divu_by0", dif.dout, ONES);
    issue(OP_REMU, 64'd5, 64'd0, 5'd7);
    expect_op(OP_REMU, 64'd5, 64'd0, 5'd7, 1'b0);
    check("plan_remu_by0", dif.dout, 64'd5);
    issue(OP_DIV, MIN64, ONES, 5'd8);
    expect_op(OP_DIV, MIN64, ONES, 5'd8, 1'b0);
    check("plan_div_ovf", dif.dout, MIN64);
    issue(OP_REM, MIN64, ONES, 5'd9);
    expect_op(OP_REM, MIN64, ONES, 5'd9, 1'b0);
    check("plan_rem_ovf", dif.dout, 64'd0);
    settle(64'd0);

    issue(OP_MUL, 64'd3, 64'd4, 5'd0);
    expect_op(OP_MUL, 64'd3, 64'd4, 5'd0, 1'b0);
    check("plan_rd0_dout", dif.dout, 64'd12);
    check("plan_rd0_we", 64'(dif.we), 64'd0);
    settle(64'd12);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = rnd_opnd();
      b  = rnd_opnd();
      rd = 5'($urandom_range(0, 31));
      issue(op, a, b, rd);
      expect_op(op, a, b, rd, (i % 5) == 0);
      if ($urandom_range(0, 1) == 1) settle(model(op, a, b));
    end

    // Known nonzero writeback state before the mid-operation reset.
    issue(OP_MUL, 64'd3, 64'd4, 5'd9);
    expect_op(OP_MUL, 64'd3, 64'd4, 5'd9, 1'b0);
    settle(64'd12);

    issue(OP_DIV, 64'd1000, 64'd7, 5'd10);
    repeat (29) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midop_rst_busy", 64'(dif.busy), 64'd0);
    check("midop_rst_done", 64'(dif.done), 64'd0);
    check("midop_rst_we", 64'(dif.we), 64'd0);
    check("midop_rst_dout", dif.dout, 64'd0);
    check("midop_rst_rw", 64'(dif.rw), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (dif.done === 1'b1 || dif.we === 1'b1) saw_done = 1'b1;
    end
    check("no_done_after_rst", 64'(saw_done), 64'd0);

    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    issue(OP_MULHU, a, b, 5'd11);
    expect_op(OP_MULHU, a, b, 5'd11, 1'b0);
    settle(model(OP_MULHU, a, b));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Sequential RV64M multiply/divide unit in the execute stage. Consumes the register file read data (Da/Db) and produces the writeback triple (result, Rw, WE) that drives the register file write port. It uses an iterative shift-add multiplier and a restoring divider: one result bit per cycle, fixed latency, start/busy/done handshake.

Parameters:
SIZE, 64, operand and result width in bits (valid values: 32 or 64)
CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > SIZE

Ports:
CLK  input  1  clock, rising-edge
RST  input  1  asynchronous, active-high reset
START  input  1  request; sampled on the CLK edge when the unit is in IDLE or DONE
OP  input  3  RV M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
A  input  SIZE  rs1 value (regfile Da)
B  input  SIZE  rs2 value (regfile Db)
RD  input  5  destination register index
BUSY  output  1  high in CALC and FIX
DONE  output  1  one-cycle pulse; Dout is valid in that cycle
Dout  output  SIZE  result, to regfile Din
Rw  output  5  latched RD, to regfile Rw
WE  output  1  DONE & (Rw != 0), to regfile WE

Behaviour:
- Reset (async, any state): state=IDLE; BUSY=0, DONE=0, WE=0, Dout=0, Rw=0; counter, accumulators and latched operands cleared. A reset mid-operation discards the operation. No writeback occurs.
- FSM states: IDLE, CALC, FIX, DONE.
  - IDLE: on START=1, latch OP, A, B, RD; convert operands to magnitudes per signedness (MULH/DIV/REM: both signed; MULHSU: A signed, B unsigned; others unsigned); record the result sign; counter=0; go to CALC.
  - CALC: one iteration per cycle for exactly SIZE cycles; counter increments; leave for FIX when counter==SIZE-1.
  - FIX: apply the sign correction (two's-complement negate if the recorded sign is negative), select the result, apply the special cases; register Dout; go to DONE.
  - DONE: DONE=1 for one cycle and WE per rule above. If START=1 in this cycle, accept it as in IDLE and go to CALC (back-to-back). Otherwise go to IDLE.
- Latency: with START sampled at edge E0, DONE/WE are high in the cycle following edge E0+SIZE+1. For SIZE=64, that is 66 cycles after acceptance. Throughput is one operation per SIZE+2 cycles.
- START in CALC/FIX is ignored (no queueing). The caller must hold the pipeline while BUSY=1.
- Dout and Rw hold their last value outside DONE. Only the DONE/WE pulse qualifies them.
- Multiply: 2*SIZE-bit product of the magnitudes. MUL returns the low SIZE bits of the signed product. MULH/MULHSU/MULHU return the high SIZE bits after sign correction of the full 2*SIZE-bit product.
- Divide: restoring division of magnitudes. The quotient takes the sign A^B. The remainder takes the sign of A.
- Divide by zero (B==0): quotient = all ones (-1) for both DIV and DIVU; remainder = A unmodified. Latency is unchanged.
- Signed overflow (DIV/REM, A=most-negative value, B=-1): quotient = A; remainder = 0. Latency is unchanged.
- All arithmetic is modulo 2^SIZE (or 2^(2*SIZE) for the product). No exceptions or flags are raised.

Decomposition:
- Shared package: OP funct3 constants (OP_MUL..OP_REMU), FSM state encodings (2-bit), helper constant for the most-negative value per SIZE.
- One natural sub-module: muldiv_signfix, a combinational block for magnitude conversion and conditional negate, instantiated for operand entry and result exit.
- The iteration datapath and FSM stay in muldiv_unit.

Test Plan:
- MUL, A=7, B=-3 (0xFFFF_FFFF_FFFF_FFFD), RD=5 -> at cycle 66: DONE=1, Dout=0xFFFF_FFFF_FFFF_FFEB, Rw=5, WE=1; BUSY=1 during cycles 1-65.
- MULHU, A=B=0xFFFF_FFFF_FFFF_FFFF -> Dout=0xFFFF_FFFF_FFFF_FFFE. MULH with the same operands -> Dout=0.
- DIV, A=-7, B=2 -> Dout=-3 (0xFFFF_FFFF_FFFF_FFFD). REM with the same operands -> Dout=-1. Issue REM with START held high in the DIV DONE cycle: it is accepted back-to-back with no idle cycle.
- DIVU 5/0 -> Dout=0xFFFF_FFFF_FFFF_FFFF. REMU 5/0 -> Dout=5. DIV 0x8000_0000_0000_0000 / -1 -> Dout=0x8000_0000_0000_0000. REM of the same -> Dout=0. All at 66-cycle latency.
- RD=0, MUL 3*4 -> DONE=1, Dout=12, WE=0.
- Assert RST at cycle 30 of a DIV -> BUSY, DONE, WE, Dout go to 0 immediately (async). No DONE afterwards. A fresh MULHU issued after release completes correctly.
